// File: rtl/ser2par.sv
// MSB-first serial-to-parallel receiver: shifts en-qualified bits from a start
// marker, then presents the DW-bit word on dout with a one-cycle valid pulse.
module ser2par #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          start,
  input  logic          x,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic          busy,
  output logic          frame_err
);

  localparam int             CW   = $clog2(DW) + 1;
  localparam logic [CW-1:0]  ONE  = CW'(1);
  localparam logic [CW-1:0]  LAST = CW'(DW - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_n;
  logic [DW-1:0] sr, sr_n;
  logic [DW-1:0] dout_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          valid_n, busy_n, frame_err_n;
  logic [DW-1:0] shifted;

  assign shifted = {sr[DW-2:0], x};

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      dout      <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      cnt       <= cnt_n;
      dout      <= dout_n;
      valid     <= valid_n;
      busy      <= busy_n;
      frame_err <= frame_err_n;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_n     = state;
    sr_n        = sr;
    cnt_n       = cnt;
    dout_n      = dout;
    busy_n      = busy;
    valid_n     = 1'b0;
    frame_err_n = 1'b0;

    case (state)
      IDLE: begin
        // Stray bits without start never reach the shift register.
        if (en && start) begin
          sr_n    = shifted;
          cnt_n   = ONE;
          busy_n  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (en) begin
          if (start) begin
            // Resync wins over completion: current bit is the new MSB.
            frame_err_n = 1'b1;
            sr_n        = shifted;
            cnt_n       = ONE;
          end else if (cnt == LAST) begin
            dout_n  = shifted;
            valid_n = 1'b1;
            cnt_n   = '0;
            busy_n  = 1'b0;
            state_n = IDLE;
          end else begin
            sr_n  = shifted;
            cnt_n = cnt + ONE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ser2par.sv
// Randomised and directed bench for ser2par: a bit-list reference model feeds
// a word scoreboard that an independent negedge monitor drains.
module tb_ser2par;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, en, start, x;
  logic [DW-1:0] dout;
  logic          valid, busy, frame_err;

  int tests  = 0;
  int failed = 0;

  // Reference model state: bits of the frame in progress, expected words.
  int            bits[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mdl_dout  = '0;
  bit            mdl_valid = 1'b0;
  bit            mdl_err   = 1'b0;
  bit            mdl_busy  = 1'b0;

  ser2par #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .x(x),
    .dout(dout), .valid(valid), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Effect of one rising edge, written as "collect bits, emit word at DW".
  function automatic void model(input bit e, input bit s, input bit b);
    logic [DW-1:0] w;
    mdl_valid = 1'b0;
    mdl_err   = 1'b0;
    if (e) begin
      if (s) begin
        if (bits.size() > 0) mdl_err = 1'b1;
        bits.delete();
        bits.push_back(b);
      end else if (bits.size() > 0) begin
        bits.push_back(b);
        if (bits.size() == DW) begin
          w = '0;
          foreach (bits[i]) w = DW'(w * 2 + bits[i]);
          exp_q.push_back(w);
          mdl_dout  = w;
          mdl_valid = 1'b1;
          bits.delete();
        end
      end
    end
    mdl_busy = (bits.size() > 0);
  endfunction

  task automatic step(input bit e, input bit s, input bit b);
    @(negedge clk);
    en = e; start = s; x = b;
    @(posedge clk);
    model(e, s, b);
  endtask

  task automatic send_word(input logic [DW-1:0] w, input int nbits, input bit gaps);
    logic [DW-1:0] v;
    v = w;
    for (int i = 0; i < nbits; i++) begin
      if (gaps)
        while ($urandom_range(0, 2) == 0) step(1'b0, 1'($urandom), 1'($urandom));
      step(1'b1, i == 0, v[DW-1-i]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_async_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_dout", dout, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    bits.delete();
    exp_q.delete();
    mdl_dout = '0; mdl_valid = 1'b0; mdl_err = 1'b0; mdl_busy = 1'b0;
    en = 1'b0; start = 1'b0; x = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: compares registered outputs mid-cycle against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("valid", valid, mdl_valid);
        check("frame_err", frame_err, mdl_err);
        check("busy", busy, mdl_busy);
        check("dout_held", dout, mdl_dout);
        if (valid) begin
          if (exp_q.size() == 0) check("valid_unexpected", 1, 0);
          else                   check("dout_word", dout, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; start = 1'b0; x = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    check("init_dout", dout, 0);
    check("init_valid", valid, 0);
    check("init_busy", busy, 0);
    check("init_frame_err", frame_err, 0);

    send_word(8'hA5, 8, 1'b0); idle(2);   // continuous enable
    send_word(8'hA5, 8, 1'b1); idle(2);   // random gaps
    send_word(8'h3C, 8, 1'b0);            // back-to-back
    send_word(8'hC3, 8, 1'b0); idle(2);
    send_word(8'hFF, 5, 1'b0);            // abort by resync
    send_word(8'h5A, 8, 1'b0); idle(2);
    repeat (20) step(1'b1, 1'b0, 1'b1);   // stray bits in IDLE
    send_word(8'h81, 8, 1'b0); idle(2);
    send_word(8'hF0, 4, 1'b0);            // async reset mid-frame
    do_async_reset();
    send_word(8'h0F, 8, 1'b0); idle(2);
    send_word(8'h7E, 7, 1'b0);            // resync at the last bit
    send_word(8'h96, 8, 1'b0); idle(2);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 1'($urandom));
    idle(3);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ser2par.md
Name: ser2par

Overview:
Serial-to-parallel receiver for the team's MSB-first serial bit stream. Collects DW bits, MSB first, qualified by a bit-enable strobe and aligned by a frame-start marker. Presents the assembled word on a registered parallel bus with a one-cycle valid pulse. Sits at the receive end of the serial link and feeds the downstream parallel logic (state machines, display, checkers).

Parameters:
DW, 8, word width in bits; legal range DW >= 2.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  reset, asynchronous, active-high
en  input  1  bit strobe; x is sampled only on rising clk edges where en=1
start  input  1  frame marker; qualifies the bit sampled in the same cycle as the frame's MSB
x  input  1  serial data in, MSB first
dout  output  DW  last completed word, registered, held until the next completion
valid  output  1  one-cycle pulse: dout was updated at the previous edge
busy  output  1  high while a frame is partially received
frame_err  output  1  one-cycle pulse: a partial frame was aborted by a new start

Behaviour:
- Reset (async, rst=1): state=IDLE, shift register=0, bit count=0, dout=0, valid=0, busy=0, frame_err=0. This holds mid-frame too: the partial word is discarded and dout is cleared.
- Internal state: shift register sr[DW-1:0], bit counter cnt of width clog2(DW)+1, FSM state {IDLE, SHIFT}.
- All other outputs are registered. valid and frame_err default to 0 on every edge unless set below.
- IDLE:
  - en=1 & start=1: sr <= {sr[DW-2:0], x}, cnt <= 1, go to SHIFT, busy <= 1.
  - Otherwise hold. Bits with en=1 & start=0 are ignored; stray bits never enter sr.
  - start=1 & en=0 is ignored, because start is only meaningful together with en.
- SHIFT:
  - en=0: hold everything. Gaps of any length are allowed.
  - en=1 & start=0 & cnt<DW-1: sr <= {sr[DW-2:0], x}, cnt <= cnt+1.
  - en=1 & start=0 & cnt==DW-1 (last bit): dout <= {sr[DW-2:0], x}, valid <= 1, cnt <= 0, busy <= 0, go to IDLE.
  - en=1 & start=1 (resync): the partial frame is discarded. frame_err <= 1, sr <= {sr[DW-2:0], x}, cnt <= 1, stay in SHIFT. The current bit becomes the new MSB. This takes priority even when cnt==DW-1, so no valid is generated.
- Latency: dout and valid are visible in the cycle after the edge that sampled the final bit. Minimum frame time is DW cycles with en held high.
- Back-to-back frames: start may be asserted in the cycle immediately after the last bit, i.e. concurrent with valid=1. The new frame's MSB is captured and no bit is lost.
- dout is stable between completions and is unaffected by aborts.
- No parity, no overrun or backpressure. The consumer must sample dout on valid.

Test Plan:
- DW=8, en=1 continuous, start=1 with the first bit, stream 1,0,1,0,0,1,0,1 -> valid pulses for exactly 1 cycle after the 8th edge, dout=8'hA5, busy high for 7 cycles then low.
- Same 0xA5 frame with en toggled 1,0,0,1,... (random gaps) -> dout=8'hA5. valid asserts only after the 8th en-qualified bit. busy holds during gaps.
- Back-to-back 8'h3C then 8'hC3, start on cycle 0 and cycle 8, en=1 -> two valid pulses 8 cycles apart, dout=3C then C3, no frame_err.
- Frame of 0xFF aborted after 5 bits by start=1 with new frame 0x5A -> frame_err pulses once at the abort. The next valid shows dout=8'h5A. The previously held dout is unchanged until then.
- Stray bits: en=1, start=0, x=1 for 20 cycles in IDLE -> no valid, busy=0, sr unaffected. A following frame 0x81 decodes correctly.
- Assert rst asynchronously (between clock edges) after 4 bits of 0xF0 -> dout=0, valid=0, busy=0 immediately. A subsequent full frame 0x0F gives dout=8'h0F.
